// File: rtl/e203_rr_arb8_onehot_pkg.sv
// Shared constants, FSM encoding and helpers for the 8-way round-robin arbiter.
// Optional burst locking is enabled with the E203_RR_ARB_LOCK_EN macro.
package e203_rr_arb8_onehot_pkg;

    localparam int E203_ARB_N  = 8;
    localparam int E203_ARB_PW = 3;

    typedef enum logic {
        E203_ARB_IDLE = 1'b0,
        E203_ARB_HOLD = 1'b1
    } arb_state_e;

    // Index of the set bit in a one-hot vector; zero vector maps to 0.
    function automatic logic [E203_ARB_PW-1:0] oh2idx(input logic [E203_ARB_N-1:0] oh);
        logic [E203_ARB_PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < E203_ARB_N; i++) begin
            if (oh[i]) idx = idx | E203_ARB_PW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/e203_rr_arb8_onehot_if.sv
// Request/grant bundle between requesters, the arbiter and the grant consumer.
// req_last exists only when E203_RR_ARB_LOCK_EN is defined.
interface e203_rr_arb8_onehot_if;
    import e203_rr_arb8_onehot_pkg::*;

    logic [E203_ARB_N-1:0] req_vld;
    logic [E203_ARB_N-1:0] req_rdy;
`ifdef E203_RR_ARB_LOCK_EN
    logic [E203_ARB_N-1:0] req_last;
`endif
    logic                  grt_vld;
    logic                  grt_rdy;
    logic [E203_ARB_N-1:0] grt_onehot;

    modport master (
        output req_vld,
`ifdef E203_RR_ARB_LOCK_EN
        output req_last,
`endif
        output grt_rdy,
        input  req_rdy,
        input  grt_vld,
        input  grt_onehot
    );

    modport slave (
        input  req_vld,
`ifdef E203_RR_ARB_LOCK_EN
        input  req_last,
`endif
        input  grt_rdy,
        output req_rdy,
        output grt_vld,
        output grt_onehot
    );

endinterface

// File: rtl/e203_rr_arb8_onehot_pick8.sv
// Circular priority pick: lowest set bit of v_i at or after p_i, wrapping 7->0.
// Duplicating v_i lets a single masked lowest-bit search cover the wrap.
module e203_rr_pick8
    import e203_rr_arb8_onehot_pkg::*;
(
    input  logic [E203_ARB_N-1:0]  v_i,
    input  logic [E203_ARB_PW-1:0] p_i,
    output logic [E203_ARB_N-1:0]  onehot_o
);

    logic [2*E203_ARB_N-1:0] dbl;
    logic [2*E203_ARB_N-1:0] mask;
    logic [2*E203_ARB_N-1:0] masked;
    logic [2*E203_ARB_N-1:0] lowest;

    assign dbl    = {v_i, v_i};
    // Upper copy stays fully enabled so indices below p_i are still reachable after wrap.
    assign mask   = ~(((2*E203_ARB_N)'(1) << p_i) - (2*E203_ARB_N)'(1));
    assign masked = dbl & mask;
    assign lowest = masked & (~masked + (2*E203_ARB_N)'(1));

    assign onehot_o = lowest[E203_ARB_N-1:0] | lowest[2*E203_ARB_N-1:E203_ARB_N];

endmodule

// File: rtl/e203_rr_arb8_onehot.sv
// 8-requester round-robin arbiter with registered one-hot grant and valid/ready handshake.
// Define E203_RR_ARB_LOCK_EN to keep the grant across a burst until req_last.
module e203_rr_arb8_onehot
    import e203_rr_arb8_onehot_pkg::*;
#(
    parameter int N_REQ    = E203_ARB_N,
    parameter int RST_PRIO = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    e203_rr_arb8_onehot_if.slave   arb
);

    arb_state_e             state_q, state_d;
    logic [E203_ARB_PW-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0]       gnt_q, gnt_d;

    logic [E203_ARB_PW-1:0] win_idx;
    logic [E203_ARB_PW-1:0] win_nxt;
    logic [N_REQ-1:0]       rem;
    logic                   hs;
    logic                   lock_hold;

    logic [E203_ARB_N-1:0]  pick_v;
    logic [E203_ARB_PW-1:0] pick_p;
    logic [E203_ARB_N-1:0]  pick_oh;

    assign win_idx = oh2idx(gnt_q);
    assign win_nxt = win_idx + E203_ARB_PW'(1);
    assign hs      = (state_q == E203_ARB_HOLD) && arb.grt_rdy;
    assign rem     = arb.req_vld & ~gnt_q;

`ifdef E203_RR_ARB_LOCK_EN
    // A still-requesting winner without its last beat keeps the grant and the pointer.
    assign lock_hold = hs && !arb.req_last[win_idx] && arb.req_vld[win_idx];
`else
    assign lock_hold = 1'b0;
`endif

    // One picker shared by the IDLE scan and the back-to-back handover.
    assign pick_v = (state_q == E203_ARB_HOLD) ? rem     : arb.req_vld;
    assign pick_p = (state_q == E203_ARB_HOLD) ? win_nxt : ptr_q;

    e203_rr_pick8 u_pick (
        .v_i      (pick_v),
        .p_i      (pick_p),
        .onehot_o (pick_oh)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= E203_ARB_IDLE;
            ptr_q   <= E203_ARB_PW'(RST_PRIO);
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            E203_ARB_IDLE: begin
                if (|arb.req_vld) begin
                    gnt_d   = pick_oh;
                    state_d = E203_ARB_HOLD;
                end
            end
            E203_ARB_HOLD: begin
                if (hs && !lock_hold) begin
                    ptr_d = win_nxt;
                    if (|rem) begin
                        gnt_d = pick_oh;
                    end else begin
                        gnt_d   = '0;
                        state_d = E203_ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = E203_ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        arb.req_rdy    = '0;
        arb.grt_vld    = (state_q == E203_ARB_HOLD);
        arb.grt_onehot = arb.grt_vld ? gnt_q : '0;
        if (hs && !rst_i) arb.req_rdy = gnt_q;
    end

endmodule

// File: tb/tb_e203_rr_arb8_onehot.sv
// Scoreboard bench for e203_rr_arb8_onehot: stimulus queues expected grants, monitor checks handshakes.
// Lock scenario runs only when E203_RR_ARB_LOCK_EN is defined.
module tb_e203_rr_arb8_onehot;
    import e203_rr_arb8_onehot_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    e203_rr_arb8_onehot_if bus();

    e203_rr_arb8_onehot #(.N_REQ(8), .RST_PRIO(0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .arb   (bus)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Requester model: a requester drops its request after being accepted.
    task automatic step_drop;
        logic [7:0] r;
        @(negedge clk);
        r = bus.req_rdy;
        @(posedge clk);
        #1;
        bus.req_vld = bus.req_vld & ~r;
    endtask

    task automatic do_reset;
        bus.grt_rdy = 1'b0;
        bus.req_vld = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output int cyc);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            tick();
            cyc++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.grt_vld && bus.grt_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got %0h expected none", bus.grt_onehot);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("grant", bus.grt_onehot, mon_exp);
                chk("req_rdy", bus.req_rdy, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        bus.req_vld = 8'hFF;
        bus.grt_rdy = 1'b1;
`ifdef E203_RR_ARB_LOCK_EN
        bus.req_last = 8'h00;
`endif
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_grt_vld", bus.grt_vld, 0);
        chk("rst_onehot", bus.grt_onehot, 8'h00);
        chk("rst_req_rdy", bus.req_rdy, 8'h00);

        // Full load: 01..80 then wrap to 01, one grant per cycle.
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(1 << (i % 8)));
        wait_drain(40, cyc);
        chk("fullload_cycles", cyc, 10);
        do_reset();

        // Two requesters back to back, then idle.
        bus.req_vld = 8'h81;
        bus.grt_rdy = 1'b1;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        for (int i = 0; i < 3; i++) step_drop();
        @(negedge clk);
        chk("two_idle_vld", bus.grt_vld, 0);
        chk("two_idle_oh", bus.grt_onehot, 8'h00);
        @(posedge clk);
        #1;
        do_reset();

        // Backpressure: grant holds while a new request arrives.
        bus.req_vld = 8'h04;
        bus.grt_rdy = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_onehot", bus.grt_onehot, 8'h04);
            chk("bp_req_rdy", bus.req_rdy, 8'h00);
            chk("bp_vld", bus.grt_vld, 1);
            @(posedge clk);
            #1;
            if (k == 1) bus.req_vld = bus.req_vld | 8'h02;
        end
        bus.grt_rdy = 1'b1;
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h02);
        step_drop();
        step_drop();
        @(negedge clk);
        chk("bp_idle", bus.grt_vld, 0);
        @(posedge clk);
        #1;
        do_reset();

        // Reset while 8'h10 is pending with ptr advanced to 2.
        bus.req_vld = 8'h12;
        bus.grt_rdy = 1'b1;
        exp_q.push_back(8'h02);
        step_drop();
        step_drop();
        bus.grt_rdy = 1'b0;
        @(negedge clk);
        chk("mid_pending", bus.grt_onehot, 8'h10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.grt_rdy = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", bus.req_rdy, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_vld = 8'h11;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h10);
        @(negedge clk);
        chk("mid_after_vld", bus.grt_vld, 0);
        chk("mid_after_oh", bus.grt_onehot, 8'h00);
        step_drop();
        step_drop();
        @(negedge clk);
        chk("mid_idle", bus.grt_vld, 0);
        @(posedge clk);
        #1;
        do_reset();

`ifdef E203_RR_ARB_LOCK_EN
        // Locked burst on requester 0: three beats, last on the third.
        begin
            logic [7:0] r;
            int beat;
            beat = 0;
            bus.req_vld = 8'h03;
            bus.req_last = 8'h00;
            bus.grt_rdy = 1'b1;
            exp_q.push_back(8'h01);
            exp_q.push_back(8'h01);
            exp_q.push_back(8'h01);
            exp_q.push_back(8'h02);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                r = bus.req_rdy;
                @(posedge clk);
                #1;
                if (r[0]) begin
                    beat++;
                    if (beat == 2) bus.req_last[0] = 1'b1;
                    if (beat == 3) bus.req_vld[0] = 1'b0;
                end
                if (r[1]) bus.req_vld[1] = 1'b0;
            end
            @(negedge clk);
            chk("lock_idle", bus.grt_vld, 0);
            @(posedge clk);
            #1;
            do_reset();
        end
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
